// File: rtl/feature_frame_selector.sv
// feature_frame_selector: captures the five tree features from a record stream
// and presents them as a registered vector with a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   s_valid/s_ready     input beat handshake; s_data is the feature byte,
//   s_data, s_last      s_last marks the final beat of a record
//   m_valid/m_ready     output vector handshake
//   X13..X278           captured features IDX_A..IDX_E
//   frame_err           one-cycle pulse when a record is dropped
//   drop_cnt            dropped-record count, saturating at 255
module feature_frame_selector #(
    parameter int N_FEAT = 279,
    parameter int IDX_A  = 13,
    parameter int IDX_B  = 27,
    parameter int IDX_C  = 235,
    parameter int IDX_D  = 264,
    parameter int IDX_E  = 278
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] X13,
    output logic [7:0] X27,
    output logic [7:0] X235,
    output logic [7:0] X264,
    output logic [7:0] X278,
    output logic       frame_err,
    output logic [7:0] drop_cnt
);

    localparam logic [8:0] LAST = 9'(N_FEAT - 1);
    localparam logic [8:0] IA   = 9'(IDX_A);
    localparam logic [8:0] IB   = 9'(IDX_B);
    localparam logic [8:0] IC   = 9'(IDX_C);
    localparam logic [8:0] ID   = 9'(IDX_D);
    localparam logic [8:0] IE   = 9'(IDX_E);

    typedef enum logic [1:0] {
        COLLECT,
        PEND,
        DISCARD
    } state_t;

    state_t     state, state_n;
    logic [8:0] idx, idx_n;
    logic [7:0] sh_a, sh_b, sh_c, sh_d, sh_e;
    logic       acc, col_acc, free, at_last;
    logic       hit_a, hit_b, hit_c, hit_d, hit_e;
    logic       load, err;

    // Ready depends only on state (and reset), never on m_ready.
    assign s_ready = rst_n & (state != PEND);
    assign acc     = s_valid & s_ready;
    assign col_acc = acc & (state == COLLECT);
    assign free    = ~m_valid | m_ready;
    assign at_last = (idx == LAST);

    assign hit_a = col_acc & (idx == IA);
    assign hit_b = col_acc & (idx == IB);
    assign hit_c = col_acc & (idx == IC);
    assign hit_d = col_acc & (idx == ID);
    assign hit_e = col_acc & (idx == IE);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        load    = 1'b0;
        err     = 1'b0;
        unique case (state)
            COLLECT: begin
                if (acc) begin
                    unique case (1'b1)
                        at_last & s_last: begin
                            idx_n = '0;
                            if (free) load = 1'b1;
                            else      state_n = PEND;
                        end
                        ~at_last & s_last: begin
                            err   = 1'b1;
                            idx_n = '0;
                        end
                        at_last & ~s_last: begin
                            err     = 1'b1;
                            idx_n   = '0;
                            state_n = DISCARD;
                        end
                        default: idx_n = idx + 9'd1;
                    endcase
                end
            end
            PEND: begin
                if (free) begin
                    load    = 1'b1;
                    state_n = COLLECT;
                end
            end
            DISCARD: begin
                if (acc & s_last) begin
                    idx_n   = '0;
                    state_n = COLLECT;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            idx       <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            sh_c      <= '0;
            sh_d      <= '0;
            sh_e      <= '0;
            X13       <= '0;
            X27       <= '0;
            X235      <= '0;
            X264      <= '0;
            X278      <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            frame_err <= err;
            if (hit_a) sh_a <= s_data;
            if (hit_b) sh_b <= s_data;
            if (hit_c) sh_c <= s_data;
            if (hit_d) sh_d <= s_data;
            if (hit_e) sh_e <= s_data;
            // The final beat may itself be a selected feature; bypass it.
            if (load) begin
                X13  <= hit_a ? s_data : sh_a;
                X27  <= hit_b ? s_data : sh_b;
                X235 <= hit_c ? s_data : sh_c;
                X264 <= hit_d ? s_data : sh_d;
                X278 <= hit_e ? s_data : sh_e;
            end
            if (load)         m_valid <= 1'b1;
            else if (m_ready) m_valid <= 1'b0;
            if (err && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule
